// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the pointer-width helper.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH = 16;
   localparam int unsigned FIFO_DEPTH = 8;

   // Address bits needed to index n entries, never less than one.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_if.sv
// FIFO handshake bundle. Optional FIFO_ERR_FLAGS_EN adds overflow_o/underflow_o.
interface fifo_if
   import fifo_pkg::*;
#(
   parameter int unsigned width = FIFO_WIDTH,
   parameter int unsigned depth = FIFO_DEPTH
) ();

   localparam int unsigned cnt_w = $clog2(depth + 1);

   logic [width-1:0] dato_i;
   logic             push_i;
   logic             pop_i;
   logic [width-1:0] dato_o;
   logic             full_o;
   logic             empty_o;
   logic [cnt_w-1:0] count_o;
`ifdef FIFO_ERR_FLAGS_EN
   logic             overflow_o;
   logic             underflow_o;

   modport master (
      output dato_i, push_i, pop_i,
      input  dato_o, full_o, empty_o, count_o, overflow_o, underflow_o
   );
   modport slave (
      input  dato_i, push_i, pop_i,
      output dato_o, full_o, empty_o, count_o, overflow_o, underflow_o
   );
`else
   modport master (
      output dato_i, push_i, pop_i,
      input  dato_o, full_o, empty_o, count_o
   );
   modport slave (
      input  dato_i, push_i, pop_i,
      output dato_o, full_o, empty_o, count_o
   );
`endif

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned width = FIFO_WIDTH,
   parameter int unsigned depth = FIFO_DEPTH,
   localparam int unsigned aw   = ptr_width(depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [aw-1:0]    waddr,
   input  logic [width-1:0] wdata,
   input  logic [aw-1:0]    raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO with any depth 2..256 and synchronous active-low reset.
// Optional FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module fifo
   import fifo_pkg::*;
#(
   parameter int unsigned width = FIFO_WIDTH,
   parameter int unsigned depth = FIFO_DEPTH
) (
   input logic   clk,
   input logic   rst_n,
   fifo_if.slave bus
);

   localparam int unsigned aw = ptr_width(depth);
   localparam int unsigned cw = $clog2(depth + 1);
   localparam logic [aw-1:0] last_ptr = aw'(depth - 1);
   localparam logic [aw-1:0] ptr_one  = aw'(1);
   localparam logic [cw-1:0] full_cnt = cw'(depth);
   localparam logic [cw-1:0] cnt_one  = cw'(1);

   logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
   logic [cw-1:0]    count_q, count_d;
   logic             full, empty;
   logic             do_push, do_pop;
   logic [width-1:0] rd_data;

   assign full    = (count_q == full_cnt);
   assign empty   = (count_q == '0);
   assign do_pop  = bus.pop_i & ~empty;
   // A pop on the same edge frees the slot, so a full FIFO still takes the push.
   assign do_push = bus.push_i & (~full | bus.pop_i);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_one;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_one;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + cnt_one;
         2'b01:   count_d = count_q - cnt_one;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fifo_mem #(
      .width(width),
      .depth(depth)
   ) u_mem (
      .clk  (clk),
      .we   (do_push & rst_n),
      .waddr(wr_ptr_q),
      .wdata(bus.dato_i),
      .raddr(rd_ptr_q),
      .rdata(rd_data)
   );

   assign bus.dato_o  = empty ? '0 : rd_data;
   assign bus.full_o  = full;
   assign bus.empty_o = empty;
   assign bus.count_o = count_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.push_i & full & ~bus.pop_i) overflow_q  <= 1'b1;
         if (bus.pop_i & empty)              underflow_q <= 1'b1;
      end
   end

   assign bus.overflow_o  = overflow_q;
   assign bus.underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: scoreboard queue of expected words plus directed scenarios.
module tb_fifo;
   import fifo_pkg::*;

   localparam int unsigned WIDTH = FIFO_WIDTH;
   localparam int unsigned DEPTH = FIFO_DEPTH;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fifo_if #(.width(WIDTH), .depth(DEPTH)) bus ();

   fifo #(.width(WIDTH), .depth(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] sb [$];
   int n_checks = 0;
   int n_fail   = 0;

   // Drive one clock of stimulus and update the scoreboard by the queue rules.
   task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d);
      bit acc_pop, acc_push;
      logic [WIDTH-1:0] tmp;
      acc_pop  = q && (sb.size() != 0);
      acc_push = p && ((sb.size() < DEPTH) || acc_pop);
      bus.push_i = p;
      bus.pop_i  = q;
      bus.dato_i = d;
      @(posedge clk);
      #1;
      bus.push_i = 1'b0;
      bus.pop_i  = 1'b0;
      if (acc_pop) tmp = sb.pop_front();
      if (acc_push) sb.push_back(d);
   endtask

   task automatic test_reset();
      bus.push_i = 1'b0;
      bus.pop_i  = 1'b0;
      bus.dato_i = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.empty_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty_o);
      end
      n_checks++;
      if (bus.full_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_full: got %b want 0", bus.full_o);
      end
      n_checks++;
      if (bus.count_o !== CW'(0)) begin
         n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count_o);
      end
      n_checks++;
      if (bus.dato_o !== '0) begin
         n_fail++; $display("FAIL reset_dato: got %h want 0", bus.dato_o);
      end
`ifdef FIFO_ERR_FLAGS_EN
      n_checks++;
      if ({bus.overflow_o, bus.underflow_o} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.overflow_o, bus.underflow_o});
      end
`endif
   endtask

   task automatic test_basic();
      op(1'b1, 1'b0, 16'h0006);
      op(1'b1, 1'b0, 16'h000A);
      n_checks++;
      if (bus.count_o !== CW'(2)) begin
         n_fail++; $display("FAIL basic_count: got %0d want 2", bus.count_o);
      end
      n_checks++;
      if (bus.dato_o !== sb[0]) begin
         n_fail++; $display("FAIL basic_head: got %h want %h", bus.dato_o, sb[0]);
      end
      op(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.dato_o !== 16'h000A) begin
         n_fail++; $display("FAIL basic_pop1: got %h want 000a", bus.dato_o);
      end
      op(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.empty_o !== 1'b1 || bus.dato_o !== '0) begin
         n_fail++; $display("FAIL basic_pop2: got empty=%b dato=%h want empty=1 dato=0",
                            bus.empty_o, bus.dato_o);
      end
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] exp;
      for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, WIDTH'(i));
      n_checks++;
      if (bus.full_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_full: got %b want 1", bus.full_o);
      end
      op(1'b1, 1'b0, 16'h0009);
      n_checks++;
      if (bus.count_o !== CW'(8) || bus.full_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_drop: got count=%0d full=%b want 8 1", bus.count_o, bus.full_o);
      end
`ifdef FIFO_ERR_FLAGS_EN
      n_checks++;
      if (bus.overflow_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_o);
      end
`endif
      for (int i = 1; i <= 8; i++) begin
         exp = sb[0];
         n_checks++;
         if (bus.dato_o !== exp || exp !== WIDTH'(i)) begin
            n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, bus.dato_o, WIDTH'(i));
         end
         op(1'b0, 1'b1, '0);
      end
      n_checks++;
      if (bus.empty_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_empty: got %b want 1", bus.empty_o);
      end
   endtask

   task automatic test_underflow();
      op(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.count_o !== CW'(0) || bus.empty_o !== 1'b1 || bus.dato_o !== '0) begin
         n_fail++; $display("FAIL udf_state: got count=%0d empty=%b dato=%h want 0 1 0",
                            bus.count_o, bus.empty_o, bus.dato_o);
      end
`ifdef FIFO_ERR_FLAGS_EN
      n_checks++;
      if (bus.underflow_o !== 1'b1) begin
         n_fail++; $display("FAIL udf_flag: got %b want 1", bus.underflow_o);
      end
`endif
   endtask

   task automatic test_simultaneous();
      logic [WIDTH-1:0] exp;
      // Empty: only the push happens.
      op(1'b1, 1'b1, 16'h0011);
      n_checks++;
      if (bus.count_o !== CW'(1) || bus.dato_o !== 16'h0011) begin
         n_fail++; $display("FAIL sim_empty: got count=%0d dato=%h want 1 0011",
                            bus.count_o, bus.dato_o);
      end
      op(1'b1, 1'b1, 16'h0022);
      op(1'b1, 1'b1, 16'h0033);
      n_checks++;
      if (bus.count_o !== CW'(sb.size()) || bus.dato_o !== sb[0]) begin
         n_fail++; $display("FAIL sim_mid: got count=%0d dato=%h want %0d %h",
                            bus.count_o, bus.dato_o, sb.size(), sb[0]);
      end
      exp = sb[0];
      op(1'b0, 1'b1, '0);
      n_checks++;
      if (exp !== 16'h0033 || bus.empty_o !== 1'b1) begin
         n_fail++; $display("FAIL sim_last: got %h empty=%b want 0033 1", exp, bus.empty_o);
      end
   endtask

   task automatic test_full_push_pop();
      logic [WIDTH-1:0] exp;
      for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, WIDTH'(i));
      op(1'b1, 1'b1, 16'h00AA);
      n_checks++;
      if (bus.count_o !== CW'(8) || bus.full_o !== 1'b1) begin
         n_fail++; $display("FAIL fpp_count: got count=%0d full=%b want 8 1", bus.count_o, bus.full_o);
      end
      for (int i = 2; i <= 9; i++) begin
         exp = sb[0];
         n_checks++;
         if (bus.dato_o !== exp || exp !== ((i == 9) ? 16'h00AA : WIDTH'(i))) begin
            n_fail++; $display("FAIL fpp_drain%0d: got %h want %h", i, bus.dato_o, exp);
         end
         op(1'b0, 1'b1, '0);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] exp;
      for (int c = 0; c < 300; c++) begin
         exp = (sb.size() != 0) ? sb[0] : '0;
         n_checks++;
         if (bus.dato_o !== exp || bus.count_o !== CW'(sb.size()) ||
             bus.full_o !== (sb.size() == DEPTH) || bus.empty_o !== (sb.size() == 0)) begin
            n_fail++; $display("FAIL rand_c%0d: got dato=%h count=%0d want dato=%h count=%0d",
                               c, bus.dato_o, bus.count_o, exp, sb.size());
         end
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), WIDTH'($urandom));
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) op(1'b1, 1'b0, WIDTH'(16'h0100 + i));
      bus.push_i = 1'b1;
      bus.dato_i = 16'h00EE;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.push_i = 1'b0;
      sb.delete();
      n_checks++;
      if (bus.count_o !== CW'(0) || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 ||
          bus.dato_o !== '0) begin
         n_fail++; $display("FAIL rstmid_state: got count=%0d empty=%b full=%b dato=%h want 0 1 0 0",
                            bus.count_o, bus.empty_o, bus.full_o, bus.dato_o);
      end
      op(1'b0, 1'b0, '0);
      n_checks++;
      if (bus.count_o !== CW'(0)) begin
         n_fail++; $display("FAIL rstmid_idle: got %0d want 0", bus.count_o);
      end
`ifdef FIFO_ERR_FLAGS_EN
      n_checks++;
      if ({bus.overflow_o, bus.underflow_o} !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_flags: got %b want 00", {bus.overflow_o, bus.underflow_o});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_simultaneous();
      test_full_push_pop();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter width, default 16: data word width in bits.
REQ-002 Parameter depth, default 8: number of storage entries; legal range 2..256, any integer, not only powers of two.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 dato_i  input  width  write data, sampled when push_i=1 at rising clk.
REQ-006 push_i  input  1  write request, level-sampled each rising clk edge.
REQ-007 pop_i  input  1  read request, level-sampled each rising clk edge.
REQ-008 dato_o  output  width  head-of-queue data, first-word-fall-through.
REQ-009 full_o  output  1  high when count_o == depth.
REQ-010 empty_o  output  1  high when count_o == 0.
REQ-011 count_o  output  $clog2(depth+1)  number of stored entries.

Function
REQ-012 Order SHALL be strictly first-in first-out.
REQ-013 Push accepted (push_i=1, not full): dato_i written at tail; tail advances; count +1 on the same edge.
REQ-014 Pop accepted (pop_i=1, not empty): head advances; count -1 on the same edge.
REQ-015 dato_o SHALL combinationally show the oldest entry whenever empty_o=0; it SHALL be 0 when empty_o=1.
REQ-016 After a push into an empty FIFO, dato_o SHALL be valid in the cycle after that edge. There is no additional read latency.
REQ-017 Push while full and pop_i=0: the push SHALL be dropped; contents and count SHALL be unchanged.
REQ-018 Pop while empty: the pop SHALL be ignored; no state change.
REQ-019 Simultaneous push and pop, 0 < count < depth: both SHALL be performed; count unchanged.
REQ-020 Simultaneous push and pop while full: both SHALL be performed; count stays depth; the new word goes to the tail.
REQ-021 Simultaneous push and pop while empty: only the push SHALL be performed; count becomes 1.
REQ-022 Read and write pointers SHALL wrap from depth-1 to 0.
REQ-023 full_o, empty_o and count_o SHALL be registered-state derived, with no combinational path from push_i or pop_i.

Reset
REQ-024 When rst_n=0 at a rising clk edge, the pointers and count SHALL be set to 0. empty_o then reads 1, full_o 0 and dato_o 0.
REQ-025 Reset mid-operation SHALL discard all stored data.
REQ-026 push_i and pop_i SHALL be ignored in any cycle where rst_n=0.
REQ-027 Storage array contents need no reset.

Configuration
REQ-028 Macro FIFO_ERR_FLAGS_EN defined: the module SHALL add outputs overflow_o and underflow_o (1 bit each).
- overflow_o is a sticky flag set by a dropped push.
- underflow_o is a sticky flag set by an ignored pop.
- Both flags are cleared only by reset.
REQ-029 Macro not defined: these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package fifo_pkg SHALL hold:
- the default constants FIFO_WIDTH=16 and FIFO_DEPTH=8;
- a pointer-width helper function, $clog2-based, minimum 1.
REQ-031 Storage SHALL be the sub-module fifo_mem:
- one synchronous write port and one asynchronous read port;
- parameters width and depth.
REQ-032 Pointer, count and flag control logic SHALL reside in fifo.

Verification
REQ-033 Reset, then idle -> empty_o=1, full_o=0, count_o=0, dato_o=0.
REQ-034 Push 0x0006, then push 0x000A -> count_o=2 and dato_o=0x0006. Pop -> dato_o=0x000A. Pop -> empty_o=1 and dato_o=0.
REQ-035 Push 0x0001..0x0008 -> full_o=1. Push 0x0009 -> dropped and count_o=8 (overflow_o=1 if enabled). Popping all -> 0x0001..0x0008 in order.
REQ-036 Pop while empty -> no change, count_o=0 (underflow_o=1 if enabled).
REQ-037 While full, push 0x00AA and pop together -> count_o=8. Drain order is 0x0002..0x0008, then 0x00AA. This scenario also exercises pointer wrap.
REQ-038 Push 3 words, assert rst_n=0 for one cycle while push_i=1 -> count_o=0, empty_o=1, and the push is discarded.
